pool_window_sequencer: RTL and testbench
========================================

Name: pool_window_sequencer

Overview:
- Sequences one max-pooling pass over a feature map held in a single-port buffer (1-cycle read latency).
- Each pass walks non-overlapping POOL x POOL windows in raster order and streams each window's pixels into one external pooling PE.
- Captures the PE result on its flag and writes the pooled map, densely packed, to an output buffer.
- Sits between the layer controller (start/done) and the pooling PE plus its feature-map buffers.

Parameters:
- DATA_W, 16, pixel width (signed).
- IMG_W, 8, input map width in pixels. Must be a multiple of POOL.
- IMG_H, 8, input map height in pixels. Must be a multiple of POOL.
- POOL, 2, window edge. The window holds POOL*POOL pixels.
- ADDR_W, 12, read/write address width.
- TIMEOUT, 15, maximum cycles spent waiting for pe_flag per window.

Ports:
- clk, in, 1, clock, rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, launches a pass; sampled only in IDLE.
- busy, out, 1, high from the cycle after start is accepted until DONE is entered.
- done, out, 1, one-cycle pulse when a pass completes normally.
- error, out, 1, sticky PE-timeout flag; cleared by the next accepted start or by reset.
- rd_en, out, 1, input buffer read strobe.
- rd_addr, out, ADDR_W, input buffer address.
- rd_data, in, DATA_W, signed; valid one cycle after rd_en.
- pe_start, out, 1, PE run enable; low clears the PE.
- pe_enable, out, 1, pe_data valid this cycle.
- pe_data, out, DATA_W, pixel to the PE. Equals rd_data.
- pe_flag, in, 1, PE result valid.
- pe_result, in, DATA_W, signed window maximum.
- wr_en, out, 1, output buffer write strobe.
- wr_addr, out, ADDR_W, output buffer address.
- wr_data, out, DATA_W, pooled value.

Behaviour:

Reset and idle outputs:
- On reset: state=IDLE; all counters 0.
- Reset values of outputs: busy=0, done=0, error=0, rd_en=0, rd_addr=0, pe_start=0, pe_enable=0, pe_data=rd_data, wr_en=0, wr_addr=0, wr_data=0.
- Reset during any state aborts the pass immediately. No write occurs in the cycle after reset.

Counters:
- wx, wy: pixel position within the window, 0..POOL-1.
- ox: window column, 0..IMG_W/POOL-1.
- oy: window row, 0..IMG_H/POOL-1.
- oidx: output index, 0..(IMG_W/POOL)*(IMG_H/POOL)-1.
- tcnt: timeout counter.

States:
- IDLE: if start=1, clear ox, oy, oidx and error, then go to ARM. A start pulse in any other state is ignored.
- ARM (1 cycle): pe_start=0, which clears the PE. Clear wx, wy, tcnt. Go to READ.
- READ (POOL*POOL cycles):
  - pe_start=1, rd_en=1, rd_addr=(oy*POOL+wy)*IMG_W + ox*POOL+wx.
  - wx increments; it wraps to 0 and increments wy.
  - After the last pixel (wx=wy=POOL-1), go to WAIT.
- WAIT:
  - pe_start=1, tcnt increments each cycle.
  - If pe_flag=1, latch pe_result into wr_data and go to WRITE.
  - Otherwise, if tcnt=TIMEOUT, set error=1 and go to DONE without writing.
  - If pe_flag arrives in the same cycle tcnt=TIMEOUT, the flag wins.
- WRITE (1 cycle):
  - wr_en=1, wr_addr=oidx, pe_start=1.
  - oidx increments. ox increments; it wraps to 0 and increments oy.
  - If the window just written was the last one (ox and oy both at their maximum), go to DONE; otherwise go to ARM.
- DONE (1 cycle): done=1 only if error=0; busy=0. Go to IDLE.

PE data timing:
- pe_enable is rd_en delayed by one register.
- pe_data = rd_data (combinational path).
- The PE therefore sees POOL*POOL consecutive enabled pixels. The first arrives in the cycle after the first READ cycle; the last arrives in the first WAIT cycle.
- pe_enable is never high outside those cycles.

Arithmetic:
- All address products use constant parameters and are truncated to ADDR_W.
- Elaboration must fail (static assertion) if IMG_W*IMG_H exceeds 2**ADDR_W or if POOL does not divide IMG_W and IMG_H.
- Data passes through unmodified; the signedness of pe_result is preserved.

Window throughput:
- Per window: 1 (ARM) + POOL*POOL (READ) + k (WAIT, k ≥ 1) + 1 (WRITE) cycles.
- With a PE that flags 1 cycle after its last input, k=2. That gives 8 cycles per window for POOL=2.

Test Plan:
- IMG_W=IMG_H=4, POOL=2, input = 0..15 raster, PE model flags 1 cycle after 4th pixel → exactly 4 writes, wr_addr 0..3, wr_data 5, 7, 13, 15; done pulses once; busy low again next cycle.
- Same config, all-negative input (-16..-1) → writes -11, -9, -3, -1 (signed max preserved).
- Read address order for the first window → rd_addr sequence 0, 1, 4, 5. Second window: 2, 3, 6, 7. pe_enable high for exactly 4 cycles per window; pe_start low exactly 1 cycle (ARM) before each window.
- PE model never flags, TIMEOUT=15 → no wr_en, error=1 after 16 WAIT cycles, done stays 0; a new start clears error and the next pass completes normally.
- Assert reset during the third window's READ → next cycle all outputs at reset values, no write; a new start runs a full pass from wr_addr 0.
- start held high for the whole pass and pulsed again while busy → exactly one pass per IDLE acceptance; back-to-back passes give 4 writes each.

Source files
------------

// File: rtl/pool_window_sequencer.sv
// Max-pooling window sequencer: walks non-overlapping POOL x POOL windows of a
// feature map in raster order, streams each window's pixels to an external
// pooling PE, and writes the PE's result into a densely packed output map.
module pool_window_sequencer #(
    parameter int DATA_W  = 16,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int POOL    = 2,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pe_start,
    output logic              pe_enable,
    output logic [DATA_W-1:0] pe_data,
    input  logic              pe_flag,
    input  logic [DATA_W-1:0] pe_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int OW   = IMG_W / POOL;
    localparam int OH   = IMG_H / POOL;
    localparam int NOUT = OW * OH;
    localparam int PW   = (POOL > 1)    ? $clog2(POOL)      : 1;
    localparam int OXW  = (OW > 1)      ? $clog2(OW)        : 1;
    localparam int OYW  = (OH > 1)      ? $clog2(OH)        : 1;
    localparam int OIW  = (NOUT > 1)    ? $clog2(NOUT)      : 1;
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

    localparam logic [PW-1:0]  WLAST  = PW'(POOL - 1);
    localparam logic [OXW-1:0] OXLAST = OXW'(OW - 1);
    localparam logic [OYW-1:0] OYLAST = OYW'(OH - 1);
    localparam logic [TW-1:0]  TLAST  = TW'(TIMEOUT);

    // Reject geometries the address space or window tiling cannot represent.
    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_addr_chk
        $error("pool_window_sequencer: IMG_W*IMG_H exceeds 2**ADDR_W");
    end
    if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_pool_chk
        $error("pool_window_sequencer: POOL must divide IMG_W and IMG_H");
    end

    typedef enum logic [2:0] {
        IDLE, ARM, READ, WAIT, WRITE, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   wx, wy;
    logic [OXW-1:0]  ox;
    logic [OYW-1:0]  oy;
    logic [OIW-1:0]  oidx;
    logic [TW-1:0]   tcnt;

    // Raster address of pixel (wx,wy) inside window (ox,oy), truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_of(
        input logic [OXW-1:0] ox_v, input logic [OYW-1:0] oy_v,
        input logic [PW-1:0] wx_v, input logic [PW-1:0] wy_v);
        logic [63:0] a;
        a = (64'(oy_v) * 64'(POOL) + 64'(wy_v)) * 64'(IMG_W)
            + 64'(ox_v) * 64'(POOL) + 64'(wx_v);
        return a[ADDR_W-1:0];
    endfunction

    // The PE reads straight off the buffer; its valid lags the read strobe.
    assign pe_data = rd_data;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        pe_start  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ARM;
            end
            ARM: begin
                busy      = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                busy     = 1'b1;
                pe_start = 1'b1;
                rd_en    = 1'b1;
                rd_addr  = addr_of(ox, oy, wx, wy);
                if (wx == WLAST && wy == WLAST) state_nxt = WAIT;
            end
            WAIT: begin
                busy     = 1'b1;
                pe_start = 1'b1;
                if (pe_flag)            state_nxt = WRITE;
                else if (tcnt == TLAST) state_nxt = DONE;
            end
            WRITE: begin
                busy     = 1'b1;
                pe_start = 1'b1;
                wr_en    = 1'b1;
                wr_addr  = ADDR_W'(oidx);
                if (ox == OXLAST && oy == OYLAST) state_nxt = DONE;
                else                              state_nxt = ARM;
            end
            DONE: begin
                done      = ~error;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window/pixel counters, timeout, sticky error and captured result.
    always_ff @(posedge clk) begin
        if (reset) begin
            wx      <= '0;
            wy      <= '0;
            ox      <= '0;
            oy      <= '0;
            oidx    <= '0;
            tcnt    <= '0;
            error   <= 1'b0;
            wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ox    <= '0;
                        oy    <= '0;
                        oidx  <= '0;
                        error <= 1'b0;
                    end
                end
                ARM: begin
                    wx   <= '0;
                    wy   <= '0;
                    tcnt <= '0;
                end
                READ: begin
                    if (wx == WLAST) begin
                        wx <= '0;
                        wy <= (wy == WLAST) ? '0 : wy + 1'b1;
                    end else begin
                        wx <= wx + 1'b1;
                    end
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (pe_flag)            wr_data <= pe_result;
                    else if (tcnt == TLAST) error   <= 1'b1;
                end
                WRITE: begin
                    oidx <= oidx + 1'b1;
                    if (ox == OXLAST) begin
                        ox <= '0;
                        oy <= (oy == OYLAST) ? '0 : oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // pe_enable marks the cycle rd_data is valid: one cycle after rd_en.
    always_ff @(posedge clk) begin
        if (reset) pe_enable <= 1'b0;
        else       pe_enable <= rd_en;
    end

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Scoreboard bench for pool_window_sequencer on a 4x4 map with 2x2 windows.
module tb_pool_window_sequencer;

    localparam int DATA_W  = 16;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int POOL    = 2;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int OW      = IMG_W / POOL;
    localparam int OH      = IMG_H / POOL;
    localparam int NOUT    = OW * OH;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic                     busy, done, error, rd_en, pe_start, pe_enable, wr_en;
    logic [ADDR_W-1:0]        rd_addr, wr_addr;
    logic signed [DATA_W-1:0] rd_data = '0;
    logic signed [DATA_W-1:0] pe_data, wr_data;
    logic                     pe_flag = 1'b0;
    logic signed [DATA_W-1:0] pe_result = '0;

    pool_window_sequencer #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .POOL(POOL),
        .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .error(error), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pe_start(pe_start), .pe_enable(pe_enable), .pe_data(pe_data),
        .pe_flag(pe_flag), .pe_result(pe_result), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Input buffer with one-cycle read latency.
    logic signed [DATA_W-1:0] mem [NPIX];
    always @(posedge clk) if (rd_en) rd_data <= mem[int'(rd_addr) % NPIX];

    // Pooling PE: running max, flags flag_delay cycles after its POOL*POOL-th pixel.
    int  pe_cnt = 0, dly_cnt = 0, flag_delay = 0;
    bit  armed = 0, never_flag = 0;
    logic signed [DATA_W-1:0] pe_max = '0;
    always @(posedge clk) begin
        pe_flag <= 1'b0;
        if (!pe_start) begin
            pe_cnt = 0;
            armed  = 0;
        end else begin
            if (pe_enable) begin
                if (pe_cnt == 0 || pe_data > pe_max) pe_max = pe_data;
                pe_cnt++;
                if (pe_cnt == POOL * POOL) begin
                    armed   = 1;
                    dly_cnt = flag_delay;
                end
            end
            if (armed && !(pe_enable && pe_cnt == POOL * POOL && dly_cnt != 0)) begin
                if (dly_cnt == 0) begin
                    if (!never_flag) begin
                        pe_flag   <= 1'b1;
                        pe_result <= pe_max;
                    end
                    armed = 0;
                end else begin
                    dly_cnt--;
                end
            end else if (armed) begin
                dly_cnt--;
            end
        end
    end

    // Scoreboard queues filled from the reference model.
    longint exp_rd[$];
    longint exp_wa[$];
    longint exp_wd[$];

    // Reference: enumerate windows in raster order; a window's value is its max.
    task automatic push_pass(input int nwin, input bit writes);
        for (int w = 0; w < nwin; w++) begin
            int ox = w % OW;
            int oy = w / OW;
            longint mx = 0;
            for (int wy = 0; wy < POOL; wy++)
                for (int wx = 0; wx < POOL; wx++) begin
                    int a = (oy * POOL + wy) * IMG_W + ox * POOL + wx;
                    exp_rd.push_back(a);
                    if ((wy == 0 && wx == 0) || longint'(mem[a]) > mx) mx = longint'(mem[a]);
                end
            if (writes) begin
                exp_wa.push_back(w);
                exp_wd.push_back(mx);
            end
        end
    endtask

    // Monitor: compares every read/write the DUT presents against the queues.
    int wr_cnt = 0, pe_en_cnt = 0, low_cnt = 0, wait_cnt = 0;
    logic prev_ps = 1'b0;
    always @(negedge clk) begin
        if (rd_en) begin
            if (exp_rd.size() == 0) check("rd_unexpected", longint'(rd_addr), -1);
            else                    check("rd_addr", longint'(rd_addr), exp_rd.pop_front());
        end
        if (wr_en) begin
            wr_cnt++;
            check("pe_en_per_window", pe_en_cnt, POOL * POOL);
            if (exp_wa.size() == 0) begin
                check("wr_unexpected", longint'(wr_addr), -1);
            end else begin
                check("wr_addr", longint'(wr_addr), exp_wa.pop_front());
                check("wr_data", longint'(wr_data), exp_wd.pop_front());
            end
        end
        if (pe_enable && !pe_start) check("pe_en_outside", 1, 0);
        if (!pe_start) pe_en_cnt = 0;
        else if (pe_enable) pe_en_cnt++;
        if (busy && !pe_start) begin
            low_cnt++;
            wait_cnt = 0;
        end else if (pe_start && !prev_ps) begin
            check("arm_len", low_cnt, 1);
            low_cnt = 0;
        end
        if (pe_start && !rd_en && !wr_en) wait_cnt++;
        prev_ps = pe_start;
    end

    task automatic fill(input int mode);
        for (int i = 0; i < NPIX; i++)
            case (mode)
                0:       mem[i] = DATA_W'(i);
                1:       mem[i] = DATA_W'(i - 16);
                default: mem[i] = DATA_W'($urandom);
            endcase
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One pass: stimulus, wait for DONE (bounded), then end-of-pass checks.
    task automatic run_pass(input int dly, input bit nf, input bit repulse);
        int w0, n;
        bit seen;
        flag_delay = dly;
        never_flag = nf;
        if (nf) push_pass(1, 0);
        else    push_pass(NOUT, 1);
        w0 = wr_cnt;
        pulse_start();
        seen = 0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (repulse && n == 6) start = 1'b1;
            if (repulse && n == 7) start = 1'b0;
            if (!seen && busy) begin
                seen = 1;
                check("error_cleared_on_start", error, 0);
            end
            if (seen && !busy) break;
        end
        if (n >= 400) check("pass_timeout", 1, 0);
        check("done_at_end", done, nf ? 0 : 1);
        check("error_at_end", error, nf ? 1 : 0);
        if (nf) check("wait_cycles", wait_cnt, TIMEOUT + 1);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("done_one_cycle", done, 0);
        repeat (3) @(negedge clk);
        check("idle_after", busy, 0);
        check("writes", wr_cnt - w0, nf ? 0 : NOUT);
        check("exp_queues_empty", exp_rd.size() + exp_wa.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_pe_start"}, pe_start, 0);
        check({tag, "_pe_enable"}, pe_enable, 0);
        check({tag, "_pe_data"}, pe_data, rd_data);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        int w0, n, dn;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        fill(0); run_pass(0, 0, 0);
        fill(1); run_pass(0, 0, 0);
        fill(2); run_pass(0, 1, 0);          // PE never flags: timeout
        fill(2); run_pass(0, 0, 0);          // error cleared, normal pass
        fill(2); run_pass(14, 0, 0);         // flag arrives as tcnt hits TIMEOUT
        fill(2); run_pass(15, 1, 0);         // flag one cycle too late
        fill(2); run_pass(1, 0, 1);          // start re-pulsed while busy
        for (int k = 0; k < 4; k++) begin
            fill(2);
            run_pass(int'($urandom_range(0, 3)), 0, 0);
        end

        // Reset during the third window's READ.
        fill(2);
        flag_delay = 0; never_flag = 0;
        push_pass(NOUT, 1);
        w0 = wr_cnt;
        pulse_start();
        n = 0;
        while (n < 200 && !(wr_cnt >= w0 + 2 && rd_en)) begin
            @(negedge clk);
            n++;
        end
        check("reached_third_window", wr_cnt - w0, 2);
        reset = 1'b1;
        @(posedge clk);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        @(negedge clk);
        check_reset_outputs("abort");
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_write", wr_cnt - w0, 2);
        fill(2); run_pass(0, 0, 0);

        // start held high: back-to-back passes, one per IDLE acceptance.
        fill(2);
        flag_delay = 0; never_flag = 0;
        push_pass(NOUT, 1);
        push_pass(NOUT, 1);
        w0 = wr_cnt;
        @(posedge clk); #1 start = 1'b1;
        n = 0; dn = 0;
        while (n < 400 && dn < 2) begin
            @(negedge clk);
            n++;
            if (done) dn++;
        end
        start = 1'b0;
        check("held_done_pulses", dn, 2);
        repeat (4) @(negedge clk);
        check("held_idle", busy, 0);
        check("held_writes", wr_cnt - w0, 2 * NOUT);
        check("held_queues_empty", exp_rd.size() + exp_wa.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
